// File: rtl/st_pixel_pkg.sv
// Shared widths and payload types for the Avalon-ST pixel unpacker.
// The F2H SDRAM beat carries eight 32-bit lanes; each lane holds one
// 24-bit RGB pixel in its low bits (R[23:16], G[15:8], B[7:0]).
package st_pixel_pkg;

  localparam int unsigned F2HSDRAM_DW = 256;
  localparam int unsigned LANE_W      = 32;
  localparam int unsigned PIX_W       = 24;
  localparam int unsigned LANES       = F2HSDRAM_DW / LANE_W;
  localparam int unsigned LANE_IDX_W  = $clog2(LANES);

  typedef logic [PIX_W-1:0]       pixel_t;
  typedef logic [F2HSDRAM_DW-1:0] beat_t;

endpackage

// File: rtl/st_beat_fifo.sv
// Synchronous show-ahead beat FIFO with registered occupancy flags.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   wr_en, wr_data     push request and data (ignored when full)
//   rd_en, rd_data     pop request; rd_data is the head entry
//   full, empty        registered occupancy flags
//   level              registered entry count, 0..DEPTH
//   wr_ready           registered "room available"; low during reset
module st_beat_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     wr_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_nxt;
  logic             wr_fire;
  logic             rd_fire;

  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  // Occupancy after this edge; flags are registered from it.
  always_comb begin
    count_nxt = count;
    unique case ({wr_fire, rd_fire})
      2'b10:   count_nxt = count + LW'(1);
      2'b01:   count_nxt = count - LW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      wr_ready <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      full     <= (count_nxt == LW'(DEPTH));
      empty    <= (count_nxt == LW'(0));
      wr_ready <= (count_nxt < LW'(DEPTH));
    end
  end

endmodule

// File: rtl/st_pixel_unpacker.sv
// Avalon-ST sink that buffers 256-bit DDR beats and serialises each one
// into eight 24-bit RGB pixels, lane 0 first, at up to one pixel per clock.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   st_data/st_valid/st_ready   Avalon-ST sink, ready latency 0
//   pix_data/pix_valid/pix_ready pixel stream to the video pipeline
//   fifo_level              beats buffered, not counting the beat being sent
//   underflow_cnt           saturating count of starved pixel-ready cycles
module st_pixel_unpacker
  import st_pixel_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = F2HSDRAM_DW,
  parameter int unsigned LANE_WIDTH  = LANE_W,
  parameter int unsigned PIXEL_WIDTH = PIX_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         st_data,
  input  logic                          st_valid,
  output logic                          st_ready,
  output logic [PIXEL_WIDTH-1:0]        pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          underflow_cnt
);

  localparam int unsigned NLANES = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

  logic [DATA_WIDTH-1:0]  fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_wr_en;
  logic                   fifo_rd_en;

  logic                   hold;
  logic                   hold_nxt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic [DATA_WIDTH-1:0]  beat;
  logic [DATA_WIDTH-1:0]  beat_nxt;
  logic [PIXEL_WIDTH-1:0] pix_data_nxt;
  logic                   armed;
  logic                   armed_nxt;
  logic [CNT_WIDTH-1:0]   underflow_nxt;
  logic                   xfer;
  logic                   last_lane;

  assign fifo_wr_en = st_valid && st_ready && !fifo_full;
  assign pix_valid  = hold;

  st_beat_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (fifo_wr_en),
    .wr_data  (st_data),
    .rd_en    (fifo_rd_en),
    .rd_data  (fifo_rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .wr_ready (st_ready)
  );

  // Unpacker next state: reload on the last-lane transfer to avoid a bubble.
  always_comb begin
    hold_nxt      = hold;
    idx_nxt       = idx;
    beat_nxt      = beat;
    armed_nxt     = armed;
    underflow_nxt = underflow_cnt;
    fifo_rd_en    = 1'b0;

    xfer      = hold && pix_ready;
    last_lane = (idx == IDX_W'(NLANES - 1));

    if (!fifo_empty && (!hold || (xfer && last_lane))) begin
      fifo_rd_en = 1'b1;
      hold_nxt   = 1'b1;
      idx_nxt    = '0;
      beat_nxt   = fifo_rd_data;
    end else if (xfer) begin
      if (last_lane) begin
        hold_nxt = 1'b0;
        idx_nxt  = '0;
      end else begin
        idx_nxt = idx + IDX_W'(1);
      end
    end

    // Pixel register follows the lane that will be presented next cycle.
    pix_data_nxt = beat_nxt[32'(idx_nxt) * LANE_WIDTH +: PIXEL_WIDTH];

    if (xfer) armed_nxt = 1'b1;

    // Starved cycles only count once the stream has started.
    if (armed && pix_ready && !hold && (underflow_cnt != '1)) begin
      underflow_nxt = underflow_cnt + CNT_WIDTH'(1);
    end
  end

  // Unpacker and statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold          <= 1'b0;
      idx           <= '0;
      beat          <= '0;
      pix_data      <= '0;
      armed         <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      hold          <= hold_nxt;
      idx           <= idx_nxt;
      beat          <= beat_nxt;
      pix_data      <= pix_data_nxt;
      armed         <= armed_nxt;
      underflow_cnt <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_st_pixel_unpacker.sv
// Randomised bench for st_pixel_unpacker against a queue-based reference.
module tb_st_pixel_unpacker;
  import st_pixel_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  beat_t       st_data;
  logic        st_valid;
  logic        st_ready;
  pixel_t      pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [2:0]  fifo_level;
  logic [15:0] underflow_cnt;

  logic        s_st_ready;
  pixel_t      s_pix_data;
  logic        s_pix_valid;
  logic [2:0]  s_fifo_level;
  logic [3:0]  s_underflow_cnt;

  always #5 clk = ~clk;

  st_pixel_unpacker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_data       (st_data),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt)
  );

  st_pixel_unpacker #(.CNT_WIDTH(4)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_data       (st_data),
    .st_valid      (st_valid),
    .st_ready      (s_st_ready),
    .pix_data      (s_pix_data),
    .pix_valid     (s_pix_valid),
    .pix_ready     (pix_ready),
    .fifo_level    (s_fifo_level),
    .underflow_cnt (s_underflow_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: queue of buffered beats plus the pixels still owed from the held beat.
  beat_t       m_fifo[$];
  pixel_t      m_pix[$];
  bit          m_armed;
  bit          m_started;
  bit          m_pd_zero;
  bit          m_acc;
  int unsigned m_ucnt;
  int unsigned m_ucnt4;
  int unsigned m_xfers;

  function automatic void model_reset();
    m_fifo.delete();
    m_pix.delete();
    m_armed   = 1'b0;
    m_started = 1'b0;
    m_pd_zero = 1'b1;
    m_ucnt    = 0;
    m_ucnt4   = 0;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // One clock: compare outputs, drive inputs, advance the model at the edge.
  task automatic step(input bit v, input beat_t d, input bit pr, input bit rn);
    bit     valid;
    bit     ready;
    beat_t  b;
    @(negedge clk);
    check("st_ready", 64'(st_ready), 64'(m_started && (m_fifo.size() < DEPTH)));
    check("pix_valid", 64'(pix_valid), 64'(m_pix.size() != 0));
    if (m_pix.size() != 0) check("pix_data", 64'(pix_data), 64'(m_pix[0]));
    else if (m_pd_zero)    check("pix_data_reset", 64'(pix_data), 64'(0));
    check("fifo_level", 64'(fifo_level), 64'(m_fifo.size()));
    check("underflow_cnt", 64'(underflow_cnt), 64'(m_ucnt));
    check("sat_underflow_cnt", 64'(s_underflow_cnt), 64'(m_ucnt4));
    check("sat_pix_valid", 64'(s_pix_valid), 64'(m_pix.size() != 0));

    st_valid  = v;
    st_data   = d;
    pix_ready = pr;
    rst_n     = rn;
    m_acc     = 1'b0;
    @(posedge clk);

    if (!rn) begin
      model_reset();
    end else begin
      valid = (m_pix.size() != 0);
      ready = m_started && (m_fifo.size() < DEPTH);
      if (m_armed && pr && !valid) begin
        if (m_ucnt < 65535) m_ucnt++;
        if (m_ucnt4 < 15) m_ucnt4++;
      end
      if (valid && pr) begin
        m_armed = 1'b1;
        m_xfers++;
        void'(m_pix.pop_front());
      end
      if (m_pix.size() == 0 && m_fifo.size() != 0) begin
        b = m_fifo.pop_front();
        for (int k = 0; k < 8; k++) m_pix.push_back(pixel_t'((b >> (32 * k)) & 256'hFF_FFFF));
        m_pd_zero = 1'b0;
      end
      if (v && ready) begin
        m_fifo.push_back(d);
        m_acc = 1'b1;
      end
      m_started = 1'b1;
    end
  endtask

  // Offer one beat until the model reports it accepted, with a cycle budget.
  task automatic send(input beat_t d, input bit pr);
    int unsigned n = 0;
    do begin
      step(1'b1, d, pr, 1'b1);
      n++;
    end while (!m_acc && n < 64);
    if (!m_acc) check("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int unsigned n, input bit pr);
    for (int i = 0; i < int'(n); i++) step(1'b0, '0, pr, 1'b1);
  endtask

  initial begin
    beat_t b;
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_data   = '0;
    pix_ready = 1'b0;
    m_xfers   = 0;
    repeat (3) @(posedge clk);
    model_reset();

    // Single known beat, then a long starve to saturate the narrow counter.
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = 32'hAA00_0000 | 32'(k);
    send(b, 1'b1);
    idle(30, 1'b1);

    // Back-to-back beats.
    for (int i = 0; i < 6; i++) send(rand_beat(), 1'b1);
    idle(20, 1'b1);

    // Backpressure fill, then release while the source keeps offering.
    for (int i = 0; i < 8; i++) step(1'b1, rand_beat(), 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, rand_beat(), 1'b1, 1'b1);
    idle(60, 1'b1);

    // Reset three pixels into a beat with more queued behind it.
    send(rand_beat(), 1'b1);
    send(rand_beat(), 1'b1);
    idle(2, 1'b1);
    step(1'b1, rand_beat(), 1'b1, 1'b0);
    idle(2, 1'b1);
    send(rand_beat(), 1'b1);
    idle(12, 1'b1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_beat(),
           1'($urandom_range(0, 7) < 6), 1'($urandom_range(0, 499) != 0));
    end
    idle(40, 1'b1);

    if (m_xfers < 200) check("too_few_pixels", 64'(m_xfers), 64'(200));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
